// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
// Holds the next-PC mode encodings and the mode field width.
package pc_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      PC_SEQ    = 3'd0,
      PC_BRANCH = 3'd1,
      PC_JUMP   = 3'd2,
      PC_CALL   = 3'd3,
      PC_RET    = 3'd4
   } pc_mode_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with saturating count.
// Ports: clk, rst (sync, active-high), push, pop, push_data,
//        top (current top entry), full, empty, ovf/unf (1-cycle pulses).
module pc_ras
   import pc_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             full,
   output logic             empty,
   output logic             ovf,
   output logic             unf
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

   logic [WIDTH-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]    tp;
   logic [PW-1:0]    tp_up;
   logic [PW-1:0]    tp_dn;
   logic [CW-1:0]    cnt;

   assign tp_up = tp + PW'(1);
   assign tp_dn = tp - PW'(1);
   assign top   = mem[tp];
   assign full  = (cnt == DEPTH_C);
   assign empty = (cnt == '0);

   // A push while full lands on tp+1, which is the oldest slot,
   // so overwrite-oldest falls out of the ring arithmetic.
   always_ff @(posedge clk) begin
      if (rst) begin
         tp  <= '0;
         cnt <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         ovf <= push && full;
         unf <= pop && empty;
         if (push) begin
            tp <= tp_up;
            if (!full)
               cnt <= cnt + CW'(1);
         end else if (pop && !empty) begin
            tp  <= tp_dn;
            cnt <= cnt - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[tp_up] <= push_data;
   end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with SEQ/BRANCH/JUMP/CALL/RET and a RAS.
// Ports: clk, rst (sync, active-high), ena (0 = stall), mode, data_in;
//        data_out (PC), ras_empty, ras_full, ras_ovf, ras_unf, align_err.
// Macro PC_ALIGN_CHECK_EN enables rejection of misaligned targets.
module pc_unit
   import pc_pkg::*;
#(
   parameter int              WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter int              INC       = 4,
   parameter int              RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  data_in,
   output logic [WIDTH-1:0]  data_out,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_ovf,
   output logic              ras_unf,
   output logic              align_err
);

   localparam logic [WIDTH-1:0] INC_V = WIDTH'(INC);

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] next_pc;
   logic [WIDTH-1:0] ras_top;
   logic             want_push;
   logic             want_pop;
   logic             checked;
   logic             align_bad;
   logic             take;

   assign seq_pc   = pc + INC_V;
   assign data_out = pc;

   always_comb begin
      next_pc   = pc;
      want_push = 1'b0;
      want_pop  = 1'b0;
      checked   = 1'b0;
      case (mode)
         PC_SEQ: next_pc = seq_pc;
         PC_BRANCH: begin
            next_pc = pc + data_in;
            checked = 1'b1;
         end
         PC_JUMP: begin
            next_pc = data_in;
            checked = 1'b1;
         end
         PC_CALL: begin
            next_pc   = data_in;
            want_push = 1'b1;
            checked   = 1'b1;
         end
         PC_RET: begin
            // Empty stack degrades to sequential; pop still
            // issued so the RAS raises its underflow pulse.
            next_pc  = ras_empty ? seq_pc : ras_top;
            want_pop = 1'b1;
            checked  = 1'b1;
         end
         default: next_pc = pc;
      endcase
   end

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

   assign align_bad = checked && ((next_pc & ALIGN_MASK) != '0);

   always_ff @(posedge clk) begin
      if (rst)
         align_err <= 1'b0;
      else
         align_err <= ena && align_bad;
   end
`else
   logic unused_checked;

   assign unused_checked = checked;
   assign align_bad      = 1'b0;
   assign align_err      = 1'b0;
`endif

   assign take = ena && !align_bad;

   always_ff @(posedge clk) begin
      if (rst)
         pc <= RESET_VEC;
      else if (take)
         pc <= next_pc;
   end

   pc_ras #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (take && want_push),
      .pop       (take && want_pop),
      .push_data (seq_pc),
      .top       (ras_top),
      .full      (ras_full),
      .empty     (ras_empty),
      .ovf       (ras_ovf),
      .unf       (ras_unf)
   );

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the single 32-bit enable-gated PC register.
- Generalises width, reset vector and increment.
- Adds next-PC mode selection (sequential, relative branch, absolute jump, call, return) and an internal return-address stack (RAS).
- Sits at the front of the CPU fetch path; data_out drives instruction-memory address.

Parameters:
- WIDTH, 32, PC and data width in bits.
- RESET_VEC, 0, PC value loaded on reset.
- INC, 4, sequential increment; power of two, ≥1.
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, synchronous, active-high.
- ena  input  1  update enable; 0 = stall.
- mode  input  3  next-PC operation select (see Behaviour).
- data_in  input  WIDTH  branch offset (two's complement) or absolute target.
- data_out  output  WIDTH  current PC, registered.
- ras_empty  output  1  RAS holds 0 entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_ovf  output  1  one-cycle pulse: CALL overwrote the oldest entry.
- ras_unf  output  1  one-cycle pulse: RET with empty RAS.
- align_err  output  1  one-cycle pulse: misaligned target rejected (optional feature).

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high (rst).
- Reset: data_out=RESET_VEC, RAS count=0, ras_empty=1, ras_full=0, ras_ovf=ras_unf=align_err=0. rst dominates ena and mode.
- Timing: all outputs registered; a mode applied with ena=1 at edge N is visible on data_out after edge N.
- Stall: ena=0 → PC, RAS contents, count and full/empty hold; pulse outputs 0.
- Modes when ena=1 (arithmetic modulo 2^WIDTH, wrap silently):
  - 0 SEQ: pc ← pc+INC.
  - 1 BRANCH: pc ← pc+data_in.
  - 2 JUMP: pc ← data_in.
  - 3 CALL: push pc+INC; pc ← data_in.
  - 4 RET: pc ← top of RAS; pop.
  - 5–7 reserved: pc holds, no RAS change.
- RAS is a circular buffer: top pointer plus count saturating at RAS_DEPTH.
- CALL while full: push overwrites the oldest entry, count stays RAS_DEPTH, ras_ovf=1 for one cycle.
- RET while empty: behaves as SEQ (pc ← pc+INC), count stays 0, ras_unf=1 for one cycle.
- CALL then RET returns to the value pushed; nested calls unwind LIFO.
- ras_full and ras_empty reflect the count after the edge.
- Reset mid-sequence discards all RAS entries.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: if the computed next PC for BRANCH, JUMP, CALL or RET has any of its low log2(INC) bits nonzero, pc holds, no RAS push/pop occurs, and align_err=1 for one cycle. SEQ is never checked.
- Undefined: no check; align_err tied to 0; misaligned targets are loaded as-is.

Decomposition:
- Package pc_pkg: mode encodings (PC_SEQ=3'd0, PC_BRANCH=3'd1, PC_JUMP=3'd2, PC_CALL=3'd3, PC_RET=3'd4) and the mode-width constant.
- Sub-module pc_ras: circular stack with push, pop, top, full, empty, ovf and unf; parametrised by WIDTH and RAS_DEPTH.
- pc_unit contains the next-PC mux, PC register and alignment check.

Test Plan:
- Reset and SEQ: rst=1 for 1 cycle, then ena=1, mode=SEQ for 3 cycles → data_out 0, 4, 8, 0xC.
- Stall: ena=0 for 2 cycles at pc=0x10 with mode=JUMP, data_in=0xABCDEF04 → data_out stays 0x10; then ena=1 → 0xABCDEF04.
- Branch and wrap: pc=0x100 with BRANCH data_in=0xFFFFFFF0 → 0xF0; pc=0xFFFFFFFC with SEQ → 0x0.
- Call/return nesting: at pc=0x20 CALL 0x400; at 0x400 CALL 0x800; RET → 0x404; RET → 0x24; ras_empty=1.
- RAS overflow/underflow (RAS_DEPTH=4): 5 CALLs → ras_ovf pulses on the 5th; 4 RETs return correctly; 5th RET → pc+4 with ras_unf pulse.
- Alignment, with PC_ALIGN_CHECK_EN: JUMP 0x12345678 accepted; JUMP 0x12345677 → pc holds, align_err=1 for one cycle. Without the macro → pc=0x12345677, align_err=0.
